// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sequencing NUM_REQ requesters onto one registered 1-bit ALU
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_a,
  input  logic [NUM_REQ-1:0]   req_b,
  input  logic [2*NUM_REQ-1:0] req_sel,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 alu_a,
  output logic                 alu_b,
  output logic [1:0]           alu_sel,
  input  logic                 alu_out,
  output logic                 resp_valid,
  output logic                 resp_data,
  output logic [IDW-1:0]       resp_id,
  input  logic                 resp_ready,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;

  // Search starts just past the last winner so it gets lowest priority.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == S_IDLE && gnt_any)
      req_ready = NUM_REQ'(1) << gnt_idx;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= IDW'(NUM_REQ - 1);
      alu_a      <= 1'b0;
      alu_b      <= 1'b0;
      alu_sel    <= 2'b00;
      resp_valid <= 1'b0;
      resp_data  <= 1'b0;
      resp_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            alu_a   <= req_a[gnt_idx];
            alu_b   <= req_b[gnt_idx];
            alu_sel <= req_sel[{gnt_idx, 1'b0} +: 2];
            resp_id <= gnt_idx;
            ptr     <= gnt_idx;
            state   <= S_EXEC;
          end
        end
        // ALU registers its inputs on this edge; result is ready one edge later.
        S_EXEC: state <= S_CAPT;
        S_CAPT: begin
          resp_data  <= alu_out;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_a, req_b, req_ready;
  logic [2*N-1:0] req_sel;
  logic           alu_a, alu_b, alu_out;
  logic [1:0]     alu_sel;
  logic           resp_valid, resp_data, resp_ready, busy;
  logic [IDW-1:0] resp_id;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_sel(req_sel), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_id(resp_id), .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in registered ALU (LSB of the result only).
  always @(posedge clk) begin
    if (alu_sel == 2'b11) alu_out <= alu_a & alu_b;
    else                  alu_out <= alu_a ^ alu_b;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: outstanding op, its age in edges, last winner.
  bit         m_busy;
  int         m_age, m_last, m_id, gnt_now, cyc;
  logic       m_a, m_b, m_data;
  logic [1:0] m_sel;
  bit         cons_now;
  logic       got_d[$];
  int         got_id[$];
  int         gnt_cyc[$];
  int         gnt_ids[$];

  function automatic logic alu_ref(logic a, logic b, logic [1:0] s);
    int x, y, r;
    x = int'(a);
    y = int'(b);
    case (s)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = y - x;
      default: r = x * y;
    endcase
    return r[0];
  endfunction

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_last = N - 1; m_id = 0;
    m_a = 0; m_b = 0; m_sel = 0; m_data = 0;
  endtask

  task automatic step();
    int g;
    logic [N-1:0] e;
    #1;
    e = '0;
    g = pick();
    if (rst_n && !m_busy && g >= 0) e[g] = 1'b1;
    check("req_ready", req_ready, e);
    check("busy", busy, m_busy);
    check("resp_valid", resp_valid, m_busy && m_age >= 2);
    check("resp_id", resp_id, m_id);
    if (m_busy && m_age >= 2) check("resp_data", resp_data, m_data);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_sel", alu_sel, m_sel);
    cons_now = 0;
    gnt_now = -1;
    if (rst_n && m_busy && m_age >= 2 && resp_ready) begin
      cons_now = 1;
      got_d.push_back(resp_data);
      got_id.push_back(int'(resp_id));
    end
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1; m_age = 0; m_id = g; m_last = g; gnt_now = g;
        m_a = req_a[g]; m_b = req_b[g]; m_sel = req_sel[2*g +: 2];
        m_data = alu_ref(m_a, m_b, m_sel);
        gnt_cyc.push_back(cyc);
        gnt_ids.push_back(g);
      end
    end else if (cons_now) m_busy = 0;
    else if (m_age < 2) m_age++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) step();
    check("rst_resp_data", resp_data, 0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0;
    resp_ready = 1'b1;
    while (m_busy && n < 20) begin step(); n++; end
    check("drain_timeout", m_busy, 0);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!(m_busy && m_age >= 2) && n < 20) begin step(); n++; end
    check("wait_resp_timeout", m_busy && m_age >= 2, 1);
  endtask

  logic exp_codes[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int   exp_rr[6]    = '{0, 1, 2, 3, 0, 1};

  initial begin
    int op;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; resp_ready = 1'b0;
    cyc = 0;
    model_reset();
    @(negedge clk);

    // Reset with everyone requesting, then first grant goes to 0.
    req_valid = '1;
    do_reset(3);
    step();
    check("first_gnt", gnt_now, 0);
    drain();

    // Requester 1 runs every op code with A=1, B=1.
    req_valid = 4'b0010; req_a = 4'b0010; req_b = 4'b0010; req_sel = '0; resp_ready = 1'b1;
    op = 0;
    got_d.delete(); got_id.delete(); gnt_cyc.delete();
    for (int n = 0; n < 40 && op < 4; n++) begin
      req_sel[3:2] = 2'(op);
      step();
      if (gnt_now == 1) op++;
      if (op == 4) req_valid = '0;
    end
    drain();
    check("codes_n", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      check("code_data", got_d[i], exp_codes[i]);
      check("code_id", got_id[i], 1);
      if (i > 0) check("code_gap", gnt_cyc[i] - gnt_cyc[i-1], 4);
    end

    // Round-robin with all valid from reset.
    req_valid = '0;
    do_reset(2);
    gnt_ids.delete();
    req_valid = '1; resp_ready = 1'b1;
    for (int n = 0; n < 60 && gnt_ids.size() < 6; n++) step();
    drain();
    check("rr_n", gnt_ids.size(), 6);
    for (int i = 0; i < 6 && i < gnt_ids.size(); i++) check("rr_id", gnt_ids[i], exp_rr[i]);

    // Back-pressure: hold RESP 10 cycles, then consume and regrant.
    req_valid = 4'b0100; req_a = 4'b0100; req_b = '0; resp_ready = 1'b0;
    wait_resp();
    req_valid = 4'b0101;
    repeat (10) step();
    check("bp_hold", cons_now, 0);
    resp_ready = 1'b1;
    step();
    check("bp_consume", cons_now, 1);
    step();
    check("bp_regrant", gnt_now, 0);
    drain();

    // Reset during CAPT aborts the op; regrant goes to 0.
    req_valid = 4'b0001; req_a = 4'b0001; req_b = '0; req_sel = '0; resp_ready = 1'b1;
    op = 0;
    while (gnt_now != 0 && op < 20) begin step(); op++; end
    check("mid_gnt", gnt_now, 0);
    step();
    rst_n = 1'b0;
    model_reset();
    req_valid = '1;
    got_d.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    check("mid_regrant", gnt_now, 0);
    check("mid_no_resp", got_d.size(), 0);
    drain();

    // Requester 0 withdraws during RESP of requester 1.
    req_valid = 4'b0010; resp_ready = 1'b0;
    got_id.delete();
    wait_resp();
    req_valid = 4'b0011;
    step(); step();
    req_valid = 4'b0010;
    step();
    resp_ready = 1'b1;
    step();
    step();
    check("wd_gnt", gnt_now, 1);
    drain();
    foreach (got_id[i]) check("wd_id", got_id[i], 1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      req_valid  = N'($urandom);
      req_a      = N'($urandom);
      req_b      = N'($urandom);
      req_sel    = (2*N)'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
